// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, register offsets,
// CTRL/STAT bit positions and the majority helper used by the optional glitch filter.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRx,
    StRxAck,
    StTx,
    StTxAck,
    StWait
  } stateE;

  typedef logic [1:0] regAddrT;

  localparam regAddrT RegCtrl = 2'b00;
  localparam regAddrT RegAddr = 2'b01;
  localparam regAddrT RegData = 2'b10;
  localparam regAddrT RegStat = 2'b11;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlGcallBit = 1;

  localparam int unsigned StatRxfBit  = 0;
  localparam int unsigned StatTxeBit  = 1;
  localparam int unsigned StatNackBit = 2;
  localparam int unsigned StatOvrBit  = 3;
  localparam int unsigned StatRwBit   = 14;
  localparam int unsigned StatBusyBit = 15;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Register-access bus of the I2C target.
//   i_memAddr    : register select (CTRL/ADDR/DATA/STAT)
//   i_memDataIn  : write data
//   i_memWrEn    : one-cycle write strobe
//   o_memDataOut : combinational read data of the selected register
// master: the register host; slave: the I2C target.
interface i2c_target_if;
  import i2c_target_pkg::*;

  regAddrT     i_memAddr;
  logic [15:0] i_memDataIn;
  logic        i_memWrEn;
  logic [15:0] o_memDataOut;

  modport master (
    output i_memAddr,
    output i_memDataIn,
    output i_memWrEn,
    input  o_memDataOut
  );

  modport slave (
    input  i_memAddr,
    input  i_memDataIn,
    input  i_memWrEn,
    output o_memDataOut
  );

endinterface

// File: rtl/i2c_pin_sync.sv
// Two-flop synchronizer for one I2C bus line, with rise/fall pulses derived from the
// synchronized level. Defining I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority
// filter after the synchronizer (2 extra cycles of latency).
//   i_clk, i_rstn : clock, async active-low reset (line assumed idle-high)
//   i_pin         : raw bus line, asynchronous to i_clk
//   o_level       : synchronized (and optionally filtered) level
//   o_rise/o_fall : one-cycle pulses on level transitions
module i2c_pin_sync
  import i2c_target_pkg::*;
(
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] syncQ;
  logic       levelPrevQ;
  logic       level;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      syncQ <= 2'b11;
    end else begin
      syncQ <= {syncQ[0], i_pin};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] histQ;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      histQ <= 3'b111;
    end else begin
      histQ <= {histQ[1:0], syncQ[1]};
    end
  end

  // A new value wins once it occupies two of the three taps.
  assign level = majority3(histQ);
`else
  assign level = syncQ[1];
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      levelPrevQ <= 1'b1;
    end else begin
      levelPrevQ <= level;
    end
  end

  assign o_level = level;
  assign o_rise  = level & ~levelPrevQ;
  assign o_fall  = ~level & levelPrevQ;

endmodule

// File: rtl/i2c_target.sv
// I2C target (slave) with a 4-register host interface.
//   i_clk, i_rstn             : clock, async active-low reset
//   memBus (slave)            : register access (CTRL, ADDR, DATA, STAT)
//   i_pinSCLIn, i_pinSDAIn    : raw bus lines
//   o_pinSDAOut               : constant 0 (open-drain low level)
//   o_pinSDADir               : 1 pulls SDA low, 0 releases it
// Optional: I2C_TARGET_GLITCH_FILTER_EN enables a majority filter in i2c_pin_sync.
module i2c_target
  import i2c_target_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  i2c_target_if.slave memBus,
  input  logic        i_pinSCLIn,
  input  logic        i_pinSDAIn,
  output logic        o_pinSDAOut,
  output logic        o_pinSDADir
);

  logic scl, sclRise, sclFall;
  logic sda, sdaRise, sdaFall;

  i2c_pin_sync uSclSync (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_pin   (i_pinSCLIn),
    .o_level (scl),
    .o_rise  (sclRise),
    .o_fall  (sclFall)
  );

  i2c_pin_sync uSdaSync (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_pin   (i_pinSDAIn),
    .o_level (sda),
    .o_rise  (sdaRise),
    .o_fall  (sdaFall)
  );

  stateE      stateQ, stateD;
  logic [2:0] bitCntQ, bitCntD;
  logic [7:0] shiftQ, shiftD;
  logic [7:0] txShiftQ, txShiftD;
  logic [7:0] dataQ, dataD;
  logic [1:0] ctrlQ, ctrlD;
  logic [6:0] addrQ, addrD;
  logic       rxfQ, rxfD, txeQ, txeD, nackQ, nackD, ovrQ, ovrD;
  logic       rwQ, rwD;
  // Second half of an ACK slot: the ACK bit is being held until the next SCL fall.
  logic       ackOnQ, ackOnD;
  logic       sdaDirQ, sdaDirD;

  logic       wrCtrl, wrAddr, wrData, wrStat;
  logic [3:0] w1c;
  logic       startCond, stopCond, addrMatch;
  logic       setRxf, setTxe, setNack, setOvr, latchRx;
  logic [2:0] txBitIdx;
  logic       unusedDataIn;

  assign startCond    = sdaFall & scl;
  assign stopCond     = sdaRise & scl;
  assign addrMatch    = (shiftQ[7:1] == addrQ) ||
                        (ctrlQ[CtrlGcallBit] && (shiftQ[7:1] == 7'd0));
  assign txBitIdx     = 3'd7 - bitCntQ;
  assign unusedDataIn = ^memBus.i_memDataIn[15:8];

  // Host register writes and flag updates; hardware sets win over same-cycle clears.
  always_comb begin
    wrCtrl = memBus.i_memWrEn && (memBus.i_memAddr == RegCtrl);
    wrAddr = memBus.i_memWrEn && (memBus.i_memAddr == RegAddr);
    wrData = memBus.i_memWrEn && (memBus.i_memAddr == RegData);
    wrStat = memBus.i_memWrEn && (memBus.i_memAddr == RegStat);
    w1c    = wrStat ? memBus.i_memDataIn[3:0] : 4'b0000;

    ctrlD  = wrCtrl ? memBus.i_memDataIn[1:0] : ctrlQ;
    addrD  = wrAddr ? memBus.i_memDataIn[6:0] : addrQ;
    dataD  = dataQ;
    if (latchRx) begin
      dataD = shiftQ;
    end else if (wrData) begin
      dataD = memBus.i_memDataIn[7:0];
    end

    rxfD  = (rxfQ & ~w1c[StatRxfBit]) | setRxf;
    txeD  = (txeQ & ~w1c[StatTxeBit] & ~wrData) | setTxe;
    nackD = (nackQ & ~w1c[StatNackBit]) | setNack;
    ovrD  = (ovrQ & ~w1c[StatOvrBit]) | setOvr;
  end

  // Bus protocol FSM.
  always_comb begin
    stateD   = stateQ;
    bitCntD  = bitCntQ;
    shiftD   = shiftQ;
    txShiftD = txShiftQ;
    ackOnD   = ackOnQ;
    sdaDirD  = sdaDirQ;
    rwD      = rwQ;
    setRxf   = 1'b0;
    setTxe   = 1'b0;
    setNack  = 1'b0;
    setOvr   = 1'b0;
    latchRx  = 1'b0;

    if (!ctrlD[CtrlEnBit] || stopCond) begin
      stateD  = StIdle;
      bitCntD = 3'd0;
      ackOnD  = 1'b0;
      sdaDirD = 1'b0;
    end else if (startCond) begin
      stateD  = StAddr;
      bitCntD = 3'd0;
      ackOnD  = 1'b0;
      sdaDirD = 1'b0;
    end else begin
      case (stateQ)
        StIdle, StWait: begin
        end
        StAddr, StRx: begin
          if (sclRise) begin
            shiftD  = {shiftQ[6:0], sda};
            bitCntD = bitCntQ + 3'd1;
            if (bitCntQ == 3'd7) begin
              stateD = (stateQ == StAddr) ? StAddrAck : StRxAck;
            end
          end
        end
        StAddrAck: begin
          if (sclFall) begin
            if (!ackOnQ) begin
              if (addrMatch) begin
                ackOnD  = 1'b1;
                sdaDirD = 1'b1;
                rwD     = shiftQ[0];
              end else begin
                stateD  = StWait;
                sdaDirD = 1'b0;
              end
            end else begin
              ackOnD  = 1'b0;
              bitCntD = 3'd0;
              if (rwQ) begin
                // The ACK-ending fall is also the first data-bit fall of a read.
                stateD   = StTx;
                txShiftD = dataQ;
                sdaDirD  = ~dataQ[7];
              end else begin
                stateD  = StRx;
                sdaDirD = 1'b0;
              end
            end
          end
        end
        StRxAck: begin
          if (sclFall) begin
            if (!ackOnQ) begin
              ackOnD = 1'b1;
              if (rxfQ) begin
                setOvr = 1'b1;
              end else begin
                latchRx = 1'b1;
                setRxf  = 1'b1;
                sdaDirD = 1'b1;
              end
            end else begin
              ackOnD  = 1'b0;
              stateD  = StRx;
              sdaDirD = 1'b0;
            end
          end
        end
        StTx: begin
          if (sclRise) begin
            bitCntD = bitCntQ + 3'd1;
            if (bitCntQ == 3'd7) begin
              stateD = StTxAck;
              setTxe = 1'b1;
            end
          end else if (sclFall) begin
            sdaDirD = ~txShiftQ[txBitIdx];
          end
        end
        StTxAck: begin
          if (sclFall) begin
            sdaDirD = 1'b0;
          end else if (sclRise) begin
            if (!sda) begin
              stateD   = StTx;
              txShiftD = dataQ;
              bitCntD  = 3'd0;
            end else begin
              stateD  = StWait;
              setNack = 1'b1;
            end
          end
        end
        default: stateD = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stateQ   <= StIdle;
      bitCntQ  <= 3'd0;
      shiftQ   <= 8'h00;
      txShiftQ <= 8'h00;
      dataQ    <= 8'h00;
      ctrlQ    <= 2'b00;
      addrQ    <= 7'h00;
      rxfQ     <= 1'b0;
      txeQ     <= 1'b0;
      nackQ    <= 1'b0;
      ovrQ     <= 1'b0;
      rwQ      <= 1'b0;
      ackOnQ   <= 1'b0;
      sdaDirQ  <= 1'b0;
    end else begin
      stateQ   <= stateD;
      bitCntQ  <= bitCntD;
      shiftQ   <= shiftD;
      txShiftQ <= txShiftD;
      dataQ    <= dataD;
      ctrlQ    <= ctrlD;
      addrQ    <= addrD;
      rxfQ     <= rxfD;
      txeQ     <= txeD;
      nackQ    <= nackD;
      ovrQ     <= ovrD;
      rwQ      <= rwD;
      ackOnQ   <= ackOnD;
      sdaDirQ  <= sdaDirD;
    end
  end

  always_comb begin
    memBus.o_memDataOut = 16'h0000;
    case (memBus.i_memAddr)
      RegCtrl: memBus.o_memDataOut = {14'b0, ctrlQ};
      RegAddr: memBus.o_memDataOut = {9'b0, addrQ};
      RegData: memBus.o_memDataOut = {8'b0, dataQ};
      RegStat: memBus.o_memDataOut = {(stateQ != StIdle), rwQ, 10'b0, ovrQ, nackQ, txeQ, rxfQ};
      default: memBus.o_memDataOut = 16'h0000;
    endcase
  end

  assign o_pinSDAOut = 1'b0;
  assign o_pinSDADir = sdaDirQ;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;
  import i2c_target_pkg::*;

  localparam int unsigned Quarter = 100;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;
  logic mScl   = 1'b1;
  logic mSda   = 1'b1;
  logic sclLine, sdaLine;
  logic o_pinSDAOut, o_pinSDADir;

  int checks    = 0;
  int errors    = 0;
  int pullCount = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } expT;
  expT expQ[$];

  i2c_target_if memBus ();

  i2c_target dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .memBus      (memBus),
    .i_pinSCLIn  (sclLine),
    .i_pinSDAIn  (sdaLine),
    .o_pinSDAOut (o_pinSDAOut),
    .o_pinSDADir (o_pinSDADir)
  );

  always #5 i_clk = ~i_clk;

  // Open-drain wired-AND bus.
  assign sclLine = mScl;
  assign sdaLine = mSda & ~o_pinSDADir;

  always @(posedge i_clk) if (o_pinSDADir === 1'b1) pullCount++;

  // The target may only move SDA while SCL is low.
  always @(o_pinSDADir) begin
    if (i_rstn === 1'b1) begin
      checks++;
      assert (sclLine !== 1'b1) else begin
        errors++;
        $error("FAIL sdaDirWhileSclHigh: observed scl=%b dir=%b required scl=0", sclLine,
               o_pinSDADir);
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic expectPush(input string tag, input logic [15:0] val);
    expT e;
    e.tag = tag;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic expectPop(input logic [15:0] obs);
    expT e;
    checks++;
    assert (expQ.size() != 0) else begin
      errors++;
      $error("FAIL scoreboardEmpty: observed 0x%04h expected a queued entry", obs);
    end
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic regWrite(input regAddrT a, input logic [15:0] d);
    @(negedge i_clk);
    memBus.i_memAddr   = a;
    memBus.i_memDataIn = d;
    memBus.i_memWrEn   = 1'b1;
    @(negedge i_clk);
    memBus.i_memWrEn   = 1'b0;
  endtask

  task automatic checkReg(input string tag, input regAddrT a, input logic [15:0] exp,
                          input logic [15:0] mask);
    logic [15:0] v;
    @(negedge i_clk);
    memBus.i_memAddr = a;
    #1;
    v = memBus.o_memDataOut;
    check(tag, v & mask, exp);
  endtask

  task automatic busStart();
    mSda = 1'b1; #Quarter;
    mScl = 1'b1; #Quarter;
    mSda = 1'b0; #Quarter;
    mScl = 1'b0; #Quarter;
  endtask

  task automatic busStop();
    mSda = 1'b0; #Quarter;
    mScl = 1'b1; #Quarter;
    mSda = 1'b1; #Quarter;
  endtask

  task automatic sendBit(input logic b);
    mSda = b;    #Quarter;
    mScl = 1'b1; #(2 * Quarter);
    mScl = 1'b0; #Quarter;
  endtask

  task automatic recvBit(output logic b);
    mSda = 1'b1; #Quarter;
    mScl = 1'b1; #Quarter;
    b = sdaLine; #Quarter;
    mScl = 1'b0; #Quarter;
  endtask

  task automatic writeByte(input logic [7:0] d, input logic expAck, input string tag);
    logic a;
    expectPush(tag, {15'b0, expAck});
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    recvBit(a);
    expectPop({15'b0, a});
  endtask

  task automatic readByte(input logic ackBit, input logic [7:0] expData, input string tag);
    logic [7:0] d;
    logic       b;
    expectPush(tag, {8'b0, expData});
    for (int i = 7; i >= 0; i--) begin
      recvBit(b);
      d[i] = b;
    end
    sendBit(ackBit);
    expectPop({8'b0, d});
  endtask

  initial begin
    int pc0;
    memBus.i_memAddr   = RegCtrl;
    memBus.i_memDataIn = 16'h0000;
    memBus.i_memWrEn   = 1'b0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rstSdaDir", {15'b0, o_pinSDADir}, 16'h0000);
    check("rstSdaOut", {15'b0, o_pinSDAOut}, 16'h0000);
    checkReg("rstCtrl", RegCtrl, 16'h0000, 16'hFFFF);
    checkReg("rstAddr", RegAddr, 16'h0000, 16'hFFFF);
    checkReg("rstData", RegData, 16'h0000, 16'hFFFF);
    checkReg("rstStat", RegStat, 16'h0000, 16'hFFFF);
    i_rstn = 1'b1;
    repeat (3) @(negedge i_clk);

    // Configure; upper ADDR bits are not stored
    regWrite(RegAddr, 16'hFFC2);
    checkReg("addrUpperZero", RegAddr, 16'h0042, 16'hFFFF);
    regWrite(RegCtrl, 16'h0001);

    // Write transfer
    busStart();
    writeByte(8'h84, 1'b0, "wrAddrAck");
    writeByte(8'hA5, 1'b0, "wrDataAck");
    checkReg("statBusyRx", RegStat, 16'h8001, 16'hFFFF);
    busStop();
    repeat (10) @(negedge i_clk);
    checkReg("dataAfterWrite", RegData, 16'h00A5, 16'hFFFF);
    checkReg("statAfterWrite", RegStat, 16'h0001, 16'hFFFF);

    // Overrun: RXF still set
    busStart();
    writeByte(8'h84, 1'b0, "ovrAddrAck");
    writeByte(8'h11, 1'b1, "ovrDataNack");
    busStop();
    repeat (10) @(negedge i_clk);
    checkReg("dataAfterOvr", RegData, 16'h00A5, 16'hFFFF);
    checkReg("statAfterOvr", RegStat, 16'h0009, 16'hFFFF);
    regWrite(RegStat, 16'h000F);
    checkReg("statW1cClear", RegStat, 16'h0000, 16'hFFFF);

    // Read transfer, master NACKs
    regWrite(RegData, 16'h003C);
    busStart();
    writeByte(8'h85, 1'b0, "rdAddrAck");
    readByte(1'b1, 8'h3C, "rdData");
    checkReg("statAfterNack", RegStat, 16'hC006, 16'hFFFF);
    busStop();
    repeat (10) @(negedge i_clk);
    checkReg("statAfterRdStop", RegStat, 16'h0006, 16'h800F);
    regWrite(RegStat, 16'h000F);

    // Other address: never pulled, parked until STOP
    pc0 = pullCount;
    busStart();
    writeByte(8'h86, 1'b1, "otherAddrNack");
    checkReg("statWait", RegStat, 16'h8000, 16'h800F);
    writeByte(8'h55, 1'b1, "waitByteNack");
    busStop();
    repeat (10) @(negedge i_clk);
    check("noPullOther", 16'(pullCount - pc0), 16'h0000);
    checkReg("statAfterOther", RegStat, 16'h0000, 16'h800F);

    // General call
    regWrite(RegCtrl, 16'h0003);
    busStart();
    writeByte(8'h00, 1'b0, "gcallAck");
    busStop();
    regWrite(RegCtrl, 16'h0001);
    checkReg("ctrlReadback", RegCtrl, 16'h0001, 16'hFFFF);

    // Write byte, repeated START, read
    busStart();
    writeByte(8'h84, 1'b0, "rsAddrAck");
    writeByte(8'h5A, 1'b0, "rsDataAck");
    busStart();
    writeByte(8'h85, 1'b0, "rsReadAck");
    checkReg("statRsTx", RegStat, 16'hC001, 16'hFFFF);
    readByte(1'b0, 8'h5A, "rsTxData");
    @(negedge i_clk);
    check("sdaPulledInTx", {15'b0, o_pinSDADir}, 16'h0001);

    // Asynchronous reset while pulling SDA low
    #1;
    i_rstn = 1'b0;
    #1;
    check("asyncRstRelease", {15'b0, o_pinSDADir}, 16'h0000);
    mSda = 1'b1;
    mScl = 1'b1;
    checkReg("rst2Ctrl", RegCtrl, 16'h0000, 16'hFFFF);
    checkReg("rst2Addr", RegAddr, 16'h0000, 16'hFFFF);
    checkReg("rst2Data", RegData, 16'h0000, 16'hFFFF);
    checkReg("rst2Stat", RegStat, 16'h0000, 16'hFFFF);
    i_rstn = 1'b1;
    repeat (5) @(negedge i_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
